spi_reg_bank: RTL
=================

Name: spi_reg_bank

Overview:
- Command and register layer directly downstream of the SPI slave byte engine.
- Consumes received bytes, one `rx_valid` strobe per byte, framed by a synchronised active-low chip select.
- Decodes a 1-byte command header, then performs auto-incrementing burst writes into, or reads from, a local register file.
- Presents the next byte to shift out on `tx_byte`, for the SPI slave's `data_in`.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; legal range 2..128.
- ADDR_W, 4, register index width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cs_n  input  1  chip select, already synchronised to clk; 1 = frame idle.
- rx_valid  input  1  single-cycle strobe: rx_byte holds a complete received byte.
- rx_byte  input  8  received byte, MSB-first assembled upstream.
- tx_byte  output  8  byte for the master's next transfer; feeds the SPI slave data_in.
- regs_flat  output  NUM_REGS*8  all registers; reg i occupies bits [8i+7:8i].
- wr_pulse  output  1  one-cycle pulse when a register is written.
- wr_addr  output  ADDR_W  index written; valid with wr_pulse.
- addr_err  output  1  one-cycle pulse when a command addresses index >= NUM_REGS.

Behaviour:
- Reset (rst_n=0 at clk edge): all registers 8'h00, tx_byte 8'h00, wr_pulse 0, wr_addr 0, addr_err 0, state IDLE, address pointer 0.
- States: IDLE, CMD, WRITE, READ, DROP.
- IDLE: cs_n=0 -> CMD; tx_byte forced to 8'h00.
- CMD: rx_valid -> decode rx_byte.
  - Command byte format: bit7 = 1 read / 0 write; bits[6:0] = start index.
  - Index >= NUM_REGS -> DROP, with addr_err pulse on the next cycle.
  - Otherwise load pointer; go to READ if bit7=1, WRITE if bit7=0.
- WRITE: each rx_valid writes rx_byte to reg[ptr].
  - wr_pulse=1 and wr_addr=ptr on the following cycle.
  - ptr increments.
- READ: tx_byte = reg[ptr], registered, valid 1 clk after entering READ.
  - Each rx_valid (dummy byte from master) increments ptr; tx_byte updates 1 clk later.
  - A register written in the same cycle is not visible until the following cycle.
- DROP: rx_valid bytes are discarded; tx_byte = 8'h00; no writes.
- Pointer wrap: ptr = NUM_REGS-1 increments to 0, with no error.
- cs_n=1 in any state: next state IDLE, pointer cleared, no write for that cycle.
  - rx_valid arriving in the same cycle as cs_n=1 is ignored.
- Zero-length frame (cs_n low then high with no bytes): no side effects.
- Frame ends mid-burst: writes already performed persist.
- rx_valid in IDLE is ignored.
- rst_n=0 mid-frame: full reset as above; the frame is abandoned even if cs_n stays low.
  - After reset the block enters CMD on the next cycle with cs_n=0, so the next byte is treated as a command.
- wr_pulse and addr_err are never asserted in consecutive cycles from a single rx_valid.

Optional Feature:
- Macro: SPI_REG_LOCK_EN.
- Defined: reg[0] bit0 is a lock bit.
  - While it is 1, writes to indices 1..NUM_REGS-1 are discarded: no wr_pulse, ptr still increments.
  - Writes to reg[0] always succeed, so clearing the bit unlocks.
- Not defined: no lock; reg[0] is an ordinary register.

Test Plan:
- Write burst: reset, cs_n=0, bytes 8'h02, 8'hA5, 8'h3C, cs_n=1 -> reg2=A5, reg3=3C; wr_pulse twice with wr_addr 2 then 3; all other regs 00.
- Read burst: after the above, cs_n=0, bytes 8'h82, 8'h00, 8'h00 -> tx_byte=A5 one clk after the command, then 3C, then reg4=00.
- Wrap: write command 8'h0F followed by bytes 11, 22 (NUM_REGS=16) -> reg15=11, reg0=22, no addr_err.
- Bad address: command 8'h90 then byte 55 -> addr_err single pulse, no wr_pulse, tx_byte 00, registers unchanged.
- Abort: cs_n=1 in the same cycle as the rx_valid carrying data byte 77 after command 8'h05 -> reg5 unchanged; next frame's first byte decoded as a command.
- Lock (SPI_REG_LOCK_EN): write reg0=01, then write reg3=EE -> reg3 unchanged, no wr_pulse; write reg0=00, then reg3=EE -> reg3=EE.

Source files
------------

// File: rtl/spi_reg_bank_if.sv
// Byte-level bus between the SPI slave byte engine and the register bank,
// plus the register bank's status and register-dump outputs.
interface spi_reg_bank_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4
);
  logic                  cs_n;
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic [7:0]            tx_byte;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_pulse;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  addr_err;

  modport master (
    output cs_n, rx_valid, rx_byte,
    input  tx_byte, regs_flat, wr_pulse, wr_addr, addr_err
  );

  modport slave (
    input  cs_n, rx_valid, rx_byte,
    output tx_byte, regs_flat, wr_pulse, wr_addr, addr_err
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI command/register layer: 1-byte command header, then auto-incrementing burst
// write or read of a local register file. Optional macro SPI_REG_LOCK_EN adds a lock bit in reg[0][0].
module spi_reg_bank #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input logic           clk,
  input logic           rst_n,
  spi_reg_bank_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DROP  = 3'd4
  } state_e;

  state_e                   state_q;
  logic [NUM_REGS-1:0][7:0] regs_q;
  logic [ADDR_W-1:0]        ptr_q;
  logic [7:0]               tx_q;
  logic                     wr_pulse_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic                     addr_err_q;

  logic [ADDR_W-1:0]        ptr_inc_c;
  logic                     cmd_bad_c;
  logic                     wr_block_c;

  // Pointer wraps explicitly so non-power-of-two NUM_REGS stays in range.
  always_comb begin
    ptr_inc_c = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + ADDR_W'(1);
    cmd_bad_c = (32'(bus.rx_byte[6:0]) >= NUM_REGS);
  end

`ifdef SPI_REG_LOCK_EN
  // reg[0] itself stays writable so the master can always unlock.
  assign wr_block_c = regs_q[0][0] && (ptr_q != '0);
`else
  assign wr_block_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      regs_q     <= '0;
      ptr_q      <= '0;
      tx_q       <= 8'h00;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      wr_pulse_q <= 1'b0;
      addr_err_q <= 1'b0;
      if (bus.cs_n) begin
        // Frame end wins over any byte arriving in the same cycle.
        state_q <= IDLE;
        ptr_q   <= '0;
        tx_q    <= 8'h00;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            tx_q    <= 8'h00;
          end
          CMD: begin
            if (bus.rx_valid) begin
              if (cmd_bad_c) begin
                state_q    <= DROP;
                addr_err_q <= 1'b1;
              end else begin
                ptr_q   <= ADDR_W'(bus.rx_byte[6:0]);
                state_q <= bus.rx_byte[7] ? READ : WRITE;
              end
            end
          end
          WRITE: begin
            if (bus.rx_valid) begin
              if (!wr_block_c) begin
                regs_q[ptr_q] <= bus.rx_byte;
                wr_pulse_q    <= 1'b1;
                wr_addr_q     <= ptr_q;
              end
              ptr_q <= ptr_inc_c;
            end
          end
          READ: begin
            tx_q <= regs_q[ptr_q];
            if (bus.rx_valid) ptr_q <= ptr_inc_c;
          end
          DROP: begin
            tx_q <= 8'h00;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_byte   = tx_q;
  assign bus.regs_flat = regs_q;
  assign bus.wr_pulse  = wr_pulse_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.addr_err  = addr_err_q;

endmodule
